// File: rtl/ddr_upload_reader_if.sv
// Upload/DDR bus bundle for ddr_upload_reader: HPS upload port plus Avalon read port.
// Latency: none (wires only).
// Backpressure: carries io_upload_waitReq (to HPS) and io_ddr_waitReq (from DDR).
// Ports: master = environment side (HPS strobes, DDR responses); slave = the reader.
interface ddr_upload_reader_if #(
   parameter int ADDR_WIDTH = 25
);
   logic                  io_upload_cs;
   logic                  io_upload_rd;
   logic [ADDR_WIDTH-1:0] io_upload_addr;
   logic [15:0]           io_upload_din;
   logic                  io_upload_waitReq;
   logic                  io_ddr_rd;
   logic [31:0]           io_ddr_addr;
   logic [7:0]            io_ddr_burstLength;
   logic                  io_ddr_waitReq;
   logic                  io_ddr_valid;
   logic [63:0]           io_ddr_dout;

   modport master (
      output io_upload_cs, io_upload_rd, io_upload_addr,
      input  io_upload_din, io_upload_waitReq,
      input  io_ddr_rd, io_ddr_addr, io_ddr_burstLength,
      output io_ddr_waitReq, io_ddr_valid, io_ddr_dout
   );

   modport slave (
      input  io_upload_cs, io_upload_rd, io_upload_addr,
      output io_upload_din, io_upload_waitReq,
      output io_ddr_rd, io_ddr_addr, io_ddr_burstLength,
      input  io_ddr_waitReq, io_ddr_valid, io_ddr_dout
   );
endinterface

// File: rtl/ddr_upload_reader.sv
// Serves 16-bit HPS upload reads from a one-line cache filled by 64-bit DDR bursts.
// Latency: hit -> io_upload_din one clock after the strobe; miss -> after burst + 1 cycle.
// Backpressure: io_upload_waitReq stalls HPS during a fetch; io_ddr_waitReq holds the request.
// Ports: clock/reset_n plain; bus (slave modport) carries the upload and Avalon read signals.
// The interface instance must be built with the same ADDR_WIDTH as this module.
module ddr_upload_reader #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          ADDR_WIDTH = 25,
   parameter int          BURST_LEN  = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   ddr_upload_reader_if.slave bus
);
   localparam int OFF_W  = $clog2(BURST_LEN * 8);
   localparam int BEAT_W = (OFF_W > 3) ? OFF_W - 3 : 1;
   localparam int TAG_W  = ADDR_WIDTH - OFF_W;
   // All-ones mask of the beat field; zero when a line is a single beat.
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

   state_t             state;
   logic [63:0]        line_buf [BURST_LEN];
   logic               line_vld;
   logic [TAG_W-1:0]   line_tag;
   logic [TAG_W-1:0]   req_tag;
   logic [BEAT_W-1:0]  req_beat;
   logic [1:0]         req_half;
   logic [BEAT_W-1:0]  beat_cnt;
   logic               cs_q;
   logic               sess_ok;   // session survived the whole fetch
   logic               cs_rise;
   logic               line_hit;
   logic [TAG_W-1:0]   addr_tag;
   logic [BEAT_W-1:0]  addr_beat;

   function automatic logic [15:0] half_sel(input logic [63:0] w, input logic [1:0] h);
      return w[{h, 4'b0000} +: 16];
   endfunction

   assign addr_tag  = TAG_W'(bus.io_upload_addr >> OFF_W);
   assign addr_beat = BEAT_W'(bus.io_upload_addr >> 3) & LAST_BEAT;
   assign cs_rise   = bus.io_upload_cs & ~cs_q;

   // A line from a previous session must not hit on the first cycle of a new one.
   assign line_hit = bus.io_upload_rd & bus.io_upload_cs & line_vld & ~cs_rise &
                     (line_tag == addr_tag);

   assign bus.io_upload_waitReq  = (state != IDLE) |
                                   (bus.io_upload_rd & bus.io_upload_cs & ~line_hit);
   assign bus.io_ddr_burstLength = 8'(BURST_LEN);

   // Buffer data needs no reset: it is only read once line_vld is set.
   always_ff @(posedge clock) begin
      if (state == FILL && bus.io_ddr_valid)
         line_buf[beat_cnt] <= bus.io_ddr_dout;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         line_vld          <= 1'b0;
         line_tag          <= '0;
         req_tag           <= '0;
         req_beat          <= '0;
         req_half          <= '0;
         beat_cnt          <= '0;
         cs_q              <= 1'b0;
         sess_ok           <= 1'b0;
         bus.io_upload_din <= '0;
         bus.io_ddr_rd     <= 1'b0;
         bus.io_ddr_addr   <= '0;
      end else begin
         cs_q <= bus.io_upload_cs;
         case (state)
            IDLE: begin
               if (cs_rise)
                  line_vld <= 1'b0;
               if (line_hit) begin
                  bus.io_upload_din <= half_sel(line_buf[addr_beat], bus.io_upload_addr[2:1]);
               end else if (bus.io_upload_rd && bus.io_upload_cs) begin
                  req_tag         <= addr_tag;
                  req_beat        <= addr_beat;
                  req_half        <= bus.io_upload_addr[2:1];
                  line_vld        <= 1'b0;
                  sess_ok         <= 1'b1;
                  bus.io_ddr_rd   <= 1'b1;
                  bus.io_ddr_addr <= BASE_ADDR + (32'(addr_tag) << OFF_W);
                  state           <= REQ;
               end
            end
            REQ: begin
               // Once raised the request cannot be withdrawn, even if cs drops.
               if (!bus.io_upload_cs)
                  sess_ok <= 1'b0;
               if (!bus.io_ddr_waitReq) begin
                  bus.io_ddr_rd <= 1'b0;
                  beat_cnt      <= '0;
                  state         <= FILL;
               end
            end
            FILL: begin
               if (!bus.io_upload_cs)
                  sess_ok <= 1'b0;
               if (bus.io_ddr_valid) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT)
                     state <= RESP;
               end
            end
            RESP: begin
               if (sess_ok && bus.io_upload_cs) begin
                  line_vld          <= 1'b1;
                  line_tag          <= req_tag;
                  bus.io_upload_din <= half_sel(line_buf[req_beat], req_half);
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ddr_upload_reader.sv
module tb_ddr_upload_reader;
   localparam int          AW   = 25;
   localparam int          BL   = 4;
   localparam logic [31:0] BASE = 32'h0010_0000;
   localparam int          LINE = BL * 8;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   ddr_upload_reader_if #(.ADDR_WIDTH(AW)) bus ();

   ddr_upload_reader #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int          n_cmp   = 0;
   int          n_bad   = 0;
   int          acc_cnt = 0;     // Avalon requests accepted
   logic [63:0] salt    = '0;    // varies DDR contents between sessions
   bit          m_vld   = 1'b0;  // model: cached line valid
   int          m_line  = 0;     // model: cached line index
   logic [15:0] m_din   = '0;    // model: last value returned to HPS

   always @(negedge clock)
      if (reset_n && bus.io_ddr_rd && !bus.io_ddr_waitReq) acc_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // DDR content: 64-bit word at region byte offset off.
   function automatic logic [63:0] word_at(input logic [31:0] off);
      return 64'h0011_2233_4455_6677 + salt + 64'(off >> 3);
   endfunction

   function automatic logic [15:0] hw_at(input int a);
      logic [63:0] w;
      w = word_at(32'(a) & ~32'd7);
      return w[16 * ((a >> 1) & 3) +: 16];
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic start_session();
      bus.io_upload_cs = 1'b0;
      cyc();
      bus.io_upload_cs = 1'b1;
      m_vld = 1'b0;
      cyc();
   endtask

   // One upload read; serves the DDR fetch if the model predicts a miss.
   // abort_after / rst_after: drop cs / assert reset after that many beats (0 = never).
   task automatic do_read(input int a, input int w, input int abort_after,
                          input bit stray, input int rst_after);
      bit          exp_hit;
      int          acc0;
      logic [31:0] exp_addr;
      exp_hit  = bus.io_upload_cs && m_vld && (a / LINE == m_line);
      exp_addr = BASE + 32'((a / LINE) * LINE);
      acc0     = acc_cnt;
      bus.io_upload_addr = AW'(a);
      bus.io_upload_rd   = 1'b1;
      #1;
      n_cmp++;
      if (bus.io_upload_waitReq !== !exp_hit) begin
         n_bad++;
         $display("FAIL waitreq_strobe a=%h: got %b want %b", a, bus.io_upload_waitReq, !exp_hit);
      end
      cyc();
      bus.io_upload_rd = 1'b0;
      if (exp_hit) begin
         m_din = hw_at(a);
         n_cmp++;
         if (bus.io_upload_din !== m_din || bus.io_ddr_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_data a=%h: got %h rd=%b want %h rd=0", a, bus.io_upload_din, bus.io_ddr_rd, m_din);
         end
         return;
      end
      for (int i = 0; i <= w; i++) begin
         bus.io_ddr_waitReq = (i < w);
         n_cmp++;
         if (bus.io_ddr_rd !== 1'b1 || bus.io_ddr_addr !== exp_addr) begin
            n_bad++;
            $display("FAIL ddr_req cyc%0d: got rd=%b addr=%h want rd=1 addr=%h", i, bus.io_ddr_rd, bus.io_ddr_addr, exp_addr);
         end
         cyc();
      end
      bus.io_ddr_waitReq = 1'b0;
      n_cmp++;
      if (bus.io_ddr_rd !== 1'b0 || acc_cnt != acc0 + 1) begin
         n_bad++;
         $display("FAIL ddr_accept: got rd=%b accepts=%0d want rd=0 accepts=%0d", bus.io_ddr_rd, acc_cnt - acc0, 1);
      end
      if (stray) begin
         // Strobe during a fetch must be ignored.
         bus.io_upload_rd   = 1'b1;
         bus.io_upload_addr = AW'($urandom_range(0, 255));
         cyc();
         bus.io_upload_rd   = 1'b0;
      end
      for (int n = 0; n < BL; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) cyc();
         bus.io_ddr_valid = 1'b1;
         bus.io_ddr_dout  = word_at(exp_addr - BASE + 32'(8 * n));
         cyc();
         bus.io_ddr_valid = 1'b0;
         bus.io_ddr_dout  = {$urandom, $urandom};
         if (n == abort_after - 1) begin
            bus.io_upload_cs = 1'b0;
            m_vld = 1'b0;
         end
         if (n == rst_after - 1) begin
            reset_n = 1'b0;
            #1;
            n_cmp++;
            if (bus.io_ddr_rd !== 1'b0 || bus.io_upload_waitReq !== 1'b0 || bus.io_upload_din !== 16'h0) begin
               n_bad++;
               $display("FAIL reset_in_fill: got rd=%b wait=%b din=%h want 0 0 0", bus.io_ddr_rd, bus.io_upload_waitReq, bus.io_upload_din);
            end
            bus.io_ddr_valid = 1'b1;
            cyc();
            reset_n = 1'b1;
            cyc();
            bus.io_ddr_valid = 1'b0;
            m_vld = 1'b0;
            m_din = '0;
            return;
         end
      end
      n_cmp++;
      if (bus.io_upload_waitReq !== 1'b1) begin
         n_bad++;
         $display("FAIL waitreq_resp: got %b want 1", bus.io_upload_waitReq);
      end
      cyc();
      if (bus.io_upload_cs) begin
         m_vld  = 1'b1;
         m_line = a / LINE;
         m_din  = hw_at(a);
      end
      n_cmp++;
      if (bus.io_upload_waitReq !== 1'b0 || bus.io_upload_din !== m_din || acc_cnt != acc0 + 1) begin
         n_bad++;
         $display("FAIL miss_data a=%h: got wait=%b din=%h accepts=%0d want wait=0 din=%h accepts=1",
                  a, bus.io_upload_waitReq, bus.io_upload_din, acc_cnt - acc0, m_din);
      end
   endtask

   task automatic test_reset();
      bus.io_upload_rd   = 1'b0;
      bus.io_ddr_valid   = 1'b0;
      bus.io_ddr_waitReq = 1'b0;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.io_upload_din !== 16'h0 || bus.io_upload_waitReq !== 1'b0 || bus.io_ddr_rd !== 1'b0 ||
          bus.io_ddr_addr !== 32'h0 || bus.io_ddr_burstLength !== 8'd4) begin
         n_bad++;
         $display("FAIL reset: got din=%h wait=%b rd=%b addr=%h burst=%0d want 0 0 0 0 4",
                  bus.io_upload_din, bus.io_upload_waitReq, bus.io_ddr_rd, bus.io_ddr_addr, bus.io_ddr_burstLength);
      end
      cyc();
      reset_n = 1'b1;
      m_vld = 1'b0;
      m_din = '0;
      cyc();
   endtask

   task automatic test_cold();
      salt = '0;
      start_session();
      do_read(0, 0, 0, 1'b0, 0);
      n_cmp++;
      if (bus.io_upload_din !== 16'h6677) begin
         n_bad++;
         $display("FAIL cold_read: got %h want 6677", bus.io_upload_din);
      end
   endtask

   task automatic test_hits();
      int          ha [5] = '{'h2, 'h4, 'h6, 'h8, 'h1E};
      logic [15:0] hv [5] = '{16'h4455, 16'h2233, 16'h0011, 16'h6678, 16'h0011};
      for (int i = 0; i < 5; i++) begin
         do_read(ha[i], 0, 0, 1'b0, 0);
         n_cmp++;
         if (bus.io_upload_din !== hv[i]) begin
            n_bad++;
            $display("FAIL hit_const a=%h: got %h want %h", ha[i], bus.io_upload_din, hv[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ba [4] = '{'h10, 'h12, 'h1A, 'h00};
      int acc0;
      acc0 = acc_cnt;
      for (int i = 0; i < 4; i++) begin
         bus.io_upload_addr = AW'(ba[i]);
         bus.io_upload_rd   = 1'b1;
         #1;
         n_cmp++;
         if (bus.io_upload_waitReq !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_wait a=%h: got %b want 0", ba[i], bus.io_upload_waitReq);
         end
         cyc();
         m_din = hw_at(ba[i]);
         n_cmp++;
         if (bus.io_upload_din !== m_din) begin
            n_bad++;
            $display("FAIL b2b_data a=%h: got %h want %h", ba[i], bus.io_upload_din, m_din);
         end
      end
      bus.io_upload_rd = 1'b0;
      n_cmp++;
      if (acc_cnt != acc0) begin
         n_bad++;
         $display("FAIL b2b_nofetch: got %0d want 0", acc_cnt - acc0);
      end
   endtask

   task automatic test_backpressure();
      do_read('h20, 3, 0, 1'b1, 0);
      do_read('h22, 0, 0, 1'b0, 0);
   endtask

   task automatic test_abort();
      int acc0;
      start_session();
      do_read('h20, 1, 2, 1'b0, 0);
      acc0 = acc_cnt;
      bus.io_upload_addr = AW'('h20);
      bus.io_upload_rd   = 1'b1;
      #1;
      n_cmp++;
      if (bus.io_upload_waitReq !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_no_cs_wait: got %b want 0", bus.io_upload_waitReq);
      end
      cyc();
      bus.io_upload_rd = 1'b0;
      cyc();
      n_cmp++;
      if (bus.io_ddr_rd !== 1'b0 || acc_cnt != acc0 || bus.io_upload_din !== m_din) begin
         n_bad++;
         $display("FAIL rd_no_cs: got rd=%b accepts=%0d din=%h want 0 0 %h", bus.io_ddr_rd, acc_cnt - acc0, bus.io_upload_din, m_din);
      end
      start_session();
      do_read('h20, 0, 0, 1'b0, 0);
   endtask

   task automatic test_reset_in_fill();
      do_read('h40, 1, 0, 1'b0, 2);
      do_read(0, 0, 0, 1'b0, 0);
      do_read('h6, 0, 0, 1'b0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            salt = {$urandom, $urandom};
            start_session();
         end
         if ($urandom_range(0, 4) == 0) begin
            bus.io_ddr_valid = 1'b1;
            bus.io_ddr_dout  = {$urandom, $urandom};
            cyc();
            bus.io_ddr_valid = 1'b0;
         end
         do_read($urandom_range(0, 127), $urandom_range(0, 3), 0, ($urandom_range(0, 3) == 0), 0);
      end
   endtask

   initial begin
      bus.io_upload_cs   = 1'b0;
      bus.io_upload_rd   = 1'b0;
      bus.io_upload_addr = '0;
      bus.io_ddr_waitReq = 1'b0;
      bus.io_ddr_valid   = 1'b0;
      bus.io_ddr_dout    = '0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      cyc();
      test_reset();
      test_cold();
      test_hits();
      test_back_to_back();
      test_reset();
      test_backpressure();
      test_abort();
      test_reset_in_fill();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
